// File: rtl/uart_rx_if.sv
// Host-side interface of the UART receiver: received byte, status flags and the read strobe.
// The receiver uses the master modport; the consuming logic uses the slave modport.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 rd;

  modport master (output data, valid, frame_err, overrun, input rd);
  modport slave  (input data, valid, frame_err, overrun, output rd);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a valid/rd holding register.
// rx_clk is treated as data: its synchronised rising edges form the sample tick.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk_50m,
  input  logic      rst_n,
  input  logic      rx_clk,
  input  logic      rxd,
  uart_rx_if.master bus
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  logic                 rx_clk_meta_q, rx_clk_s_q, rx_clk_prev_q;
  logic                 rxd_meta_q, rxd_s_q;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 tick_s;
  logic                 load_s;

  // Next-state logic: the frame FSM advances only on ticks; the read handshake works every cycle.
  always_comb begin
    tick_s      = rx_clk_s_q & ~rx_clk_prev_q;
    load_s      = 1'b0;
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;

    if (bus.rd && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      valid_d   = valid_q;
    end

    if (tick_s) begin
      case (state_q)
        S_IDLE: begin
          if (!rxd_s_q) begin
            state_d    = S_START;
            tick_cnt_d = {CNT_W{1'b0}};
          end else begin
            state_d    = S_IDLE;
          end
        end
        S_START: begin
          if (tick_cnt_q == CNT_HALF) begin
            tick_cnt_d = {CNT_W{1'b0}};
            bit_idx_d  = {IDX_W{1'b0}};
            // A start bit that is high again at its midpoint was only a glitch.
            state_d    = rxd_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_cnt_q == CNT_LAST) begin
            tick_cnt_d = {CNT_W{1'b0}};
            shreg_d    = {rxd_s_q, shreg_q[DATA_BITS-1:1]};
            if (bit_idx_q == IDX_LAST) begin
              state_d   = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_cnt_q == CNT_LAST) begin
            tick_cnt_d = {CNT_W{1'b0}};
            if (rxd_s_q) begin
              load_s      = 1'b1;
              state_d     = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so it is not decoded as a stream of zero bytes.
          if (rxd_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_BREAK;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // A fresh byte beats a same-cycle read; overrun only when an unread byte is replaced.
    if (load_s) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      if (valid_q && !bus.rd) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_d;
      end
    end else begin
      data_d = data_q;
    end
  end

  // State, counters, synchronisers and registered outputs.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_clk_meta_q <= 1'b1;
      rx_clk_s_q    <= 1'b1;
      rx_clk_prev_q <= 1'b1;
      rxd_meta_q    <= 1'b1;
      rxd_s_q       <= 1'b1;
      state_q       <= S_IDLE;
      tick_cnt_q    <= {CNT_W{1'b0}};
      bit_idx_q     <= {IDX_W{1'b0}};
      shreg_q       <= {DATA_BITS{1'b0}};
      data_q        <= {DATA_BITS{1'b0}};
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_clk_meta_q <= rx_clk;
      rx_clk_s_q    <= rx_clk_meta_q;
      rx_clk_prev_q <= rx_clk_s_q;
      rxd_meta_q    <= rxd;
      rxd_s_q       <= rxd_meta_q;
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver running in the clk_50m domain.
- Consumes the 16x-oversampling rx_clk produced by the baud clock generator, treating it as data, and the external serial line rxd.
- Recovers bytes and presents them in a valid/rd holding register with frame-error and overrun status, for the host-side logic downstream.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- OVERSAMPLE, 16, sample ticks per bit period; must be even.

Ports:
- clk_50m  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- rx_clk  input  1  oversample clock from the baud generator; sampled as data, never used as a clock.
- rxd  input  1  asynchronous serial line; idles high.
- rd  input  1  consumer read strobe; acknowledges the held byte.
- data  output  DATA_BITS  last good received byte.
- valid  output  1  data holds an unread byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a byte was overwritten before being read.

Behaviour:
- Interface: one clock, clk_50m; reset rst_n is asynchronous and active-low. All flops reset asynchronously on rst_n low.
- Reset values: data=0, valid=0, frame_err=0, overrun=0, state=IDLE, counters=0, synchroniser flops=1.
- Synchronisation:
  - rx_clk and rxd each pass through a 2-flop synchroniser, giving rx_clk_s and rxd_s.
  - tick is a one-cycle pulse when rx_clk_s is 1 and its previous value was 0 (rising edge).
  - All FSM activity advances only on cycles where tick=1.
  - tick period nominally 1/16 bit. Tolerate up to ±5% rate mismatch across a 10-bit frame: mid-bit sampling must stay inside every bit.
- Counters: tick_cnt, 4 bits, clog2(OVERSAMPLE); bit_idx, 3 bits; shift register shreg of DATA_BITS bits.
- FSM, all transitions on tick only:
  - IDLE: if rxd_s=0, go to START with tick_cnt=0.
  - START:
    - Increment tick_cnt each tick.
    - On the tick where tick_cnt=OVERSAMPLE/2-1 (8th tick, mid start bit): if rxd_s=0, go to DATA with tick_cnt=0, bit_idx=0.
    - Otherwise it was a glitch: return to IDLE, no status change.
  - DATA:
    - Increment tick_cnt each tick.
    - At tick_cnt=OVERSAMPLE-1: shreg <= {rxd_s, shreg[DATA_BITS-1:1]}, tick_cnt=0.
    - If bit_idx=DATA_BITS-1, go to STOP; else bit_idx++.
  - STOP:
    - At tick_cnt=OVERSAMPLE-1, sample rxd_s.
    - rxd_s=1: data<=shreg, valid<=1, go to IDLE.
    - rxd_s=0: pulse frame_err for exactly one clk_50m cycle, leave data/valid untouched, go to BREAK.
  - BREAK: stay until rxd_s=1 is seen on a tick, then go to IDLE. This keeps a held-low line or break from being decoded as repeated 0x00 frames.
- Read handshake:
  - valid=1 and rd=1 clears valid next cycle and clears overrun.
  - rd while valid=0 is ignored.
- Byte load with valid=1 and rd=0:
  - data overwritten, valid stays 1, overrun<=1 (sticky until rd).
- Byte load and rd in the same cycle:
  - The load wins: data=new byte, valid=1, overrun cleared, no overrun set.
- Latency: valid rises 1 clk_50m cycle after the tick that samples the stop bit.
- Reset mid-frame: immediate return to IDLE. The partial byte is discarded and no pulse is emitted after release.
- rx_clk stopped: the FSM freezes in its current state and no outputs change.

Test Plan:
- Byte load: rx_clk toggling every 13 cycles, rxd driven at 434 cycles/bit with 0xA5 framed (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> valid=1, data=8'hA5, frame_err never pulses; rd=1 one cycle -> valid=0 next cycle.
- Overrun: send 0x3C then 0xC3 with no rd -> data=8'hC3, valid=1, overrun=1; rd -> valid=0, overrun=0.
- Framing error: 0x55 with stop bit held 0, then rxd low for 2000 cycles, then high -> exactly one frame_err pulse, valid stays 0, data unchanged. Next frame 0x81 -> data=8'h81.
- Glitch rejection: rxd low for 60 cycles while idle -> FSM back in IDLE, valid=0, frame_err=0. Following frame 0x00 decodes correctly.
- Simultaneous: assert rd on the exact cycle valid would rise for a second byte 0x7E while the first is held -> data=8'h7E, valid=1, overrun=0.
- Reset mid-frame: pull rst_n low after bit 3 of 0xFF for 5 cycles -> all outputs 0. Line idle, then 0x12 -> data=8'h12, no frame_err.
